// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: PicoBlaze-facing 8N1 UART transmitter with a transmit FIFO.
//   clk             - system clock
//   pb_reset        - asynchronous, active-high reset
//   pb_port_id      - PicoBlaze port_id; writes accepted when equal to PORT
//   pb_out_port     - PicoBlaze out_port data byte
//   pb_write_strobe - PicoBlaze write_strobe
//   tx_buffer_full  - registered, FIFO holds DEPTH bytes
//   tx_half_full    - registered, FIFO holds at least DEPTH/2 bytes
//   tx_busy         - registered, frame in flight or FIFO not empty
//   rs232_tx        - registered serial line, idles high
module uart_tx_fifo #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned DEPTH  = 16,
  parameter logic [7:0]  PORT   = 8'h03
) (
  input  logic       clk,
  input  logic       pb_reset,
  input  logic [7:0] pb_port_id,
  input  logic [7:0] pb_out_port,
  input  logic       pb_write_strobe,
  output logic       tx_buffer_full,
  output logic       tx_half_full,
  output logic       tx_busy,
  output logic       rs232_tx
);

  localparam int unsigned DIV = CLK_HZ / BAUD;
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned BW  = $clog2(DIV);
  localparam logic [BW-1:0] DIV_LAST = BW'(DIV - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] HALF_CNT = CW'(DEPTH / 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];
  logic            tx_q, tx_d;
  logic            full_q, full_d;
  logic            half_q, half_d;
  logic            busy_q, busy_d;
  logic            accept;
  logic            pop;
  logic            bit_end;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    bit_end = (baud_q == DIV_LAST);
    // No bypass: a write while full is dropped even if a pop happens this edge.
    accept  = pb_write_strobe && (pb_port_id == PORT) && (count_q < FULL_CNT);
    baud_d  = ((state_q == IDLE) || bit_end) ? '0 : baud_q + BW'(1);

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Chain straight into the next start bit when data is waiting.
        if (bit_end) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) shift_d = mem_q[rd_ptr_q];

    mem_d = mem_q;
    if (accept) mem_d[wr_ptr_q] = pb_out_port;
    wr_ptr_d = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    if (accept && !pop)      count_d = count_q + CW'(1);
    else if (!accept && pop) count_d = count_q - CW'(1);

    // Line and flags are registered from next-state values so they change on
    // the same edge as the state/count they describe.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    full_d = (count_d == FULL_CNT);
    half_d = (count_d >= HALF_CNT);
    busy_d = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk or posedge pb_reset) begin
    if (pb_reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tx_q     <= 1'b1;
      full_q   <= 1'b0;
      half_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tx_q     <= tx_d;
      full_q   <= full_d;
      half_q   <= half_d;
      busy_q   <= busy_d;
    end
  end

  // Storage needs no reset; pointer/count reset discards its contents.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rs232_tx       = tx_q;
  assign tx_buffer_full = full_q;
  assign tx_half_full   = half_q;
  assign tx_busy        = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int FRAME = 40;  // 10 bits * DIV(4)

  logic       clk = 1'b0;
  logic       pb_reset;
  logic [7:0] pb_port_id;
  logic [7:0] pb_out_port;
  logic       pb_write_strobe;
  logic       tx_buffer_full;
  logic       tx_half_full;
  logic       tx_busy;
  logic       rs232_tx;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLK_HZ(40),
    .BAUD  (10),
    .DEPTH (16),
    .PORT  (8'h03)
  ) dut (
    .clk            (clk),
    .pb_reset       (pb_reset),
    .pb_port_id     (pb_port_id),
    .pb_out_port    (pb_out_port),
    .pb_write_strobe(pb_write_strobe),
    .tx_buffer_full (tx_buffer_full),
    .tx_half_full   (tx_half_full),
    .tx_busy        (tx_busy),
    .rs232_tx       (rs232_tx)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: FIFO as a queue, transmitter as a frame timeline.
  logic [7:0] mq[$];
  logic [7:0] m_sent[$];
  logic [7:0] rx_q[$];
  logic [7:0] m_byte = 8'h00;
  int m_edge = 0;
  int m_end = 0;
  int m_start = 0;
  int m_mis = 0;
  int mis_edge = 0;
  logic [3:0] mis_act = '0;
  logic [3:0] mis_exp = '0;

  function automatic logic exp_line();
    int b;
    if (m_edge >= m_end) return 1'b1;
    b = (m_edge - m_start) / 4;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_byte[b-1];
  endfunction

  task automatic cyc(input logic stb, input logic [7:0] pid, input logic [7:0] dat);
    logic pop, acc;
    logic [3:0] exp_v, act_v;
    pb_write_strobe = stb;
    pb_port_id      = pid;
    pb_out_port     = dat;
    @(posedge clk);
    m_edge++;
    pop = (mq.size() != 0) && (m_edge >= m_end);
    acc = stb && (pid == 8'h03) && (mq.size() < 16);
    if (pop) begin
      m_byte = mq.pop_front();
      m_sent.push_back(m_byte);
      m_start = m_edge;
      m_end   = m_edge + FRAME;
    end
    if (acc) mq.push_back(dat);
    #1;
    exp_v = {exp_line(), mq.size() == 16, mq.size() >= 8, (m_edge < m_end) || (mq.size() != 0)};
    act_v = {rs232_tx, tx_buffer_full, tx_half_full, tx_busy};
    if (act_v !== exp_v) begin
      if (m_mis == 0) begin
        mis_edge = m_edge;
        mis_act  = act_v;
        mis_exp  = exp_v;
      end
      m_mis++;
    end
    pb_write_strobe = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (mq.size() == 0 && m_edge >= m_end) break;
      cyc(1'b0, 8'h00, 8'h00);
    end
    cyc(1'b0, 8'h00, 8'h00);
  endtask

  // Independent line receiver: samples mid-bit on the falling clock edge.
  logic [7:0] dec_b;
  always begin
    @(negedge clk);
    if (pb_reset !== 1'b1 && rs232_tx === 1'b0) begin
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (4) @(negedge clk);
        dec_b[i] = rs232_tx;
      end
      repeat (4) @(negedge clk);
      rx_q.push_back(dec_b);
    end
  end

  task automatic test_reset();
    #1;
    n_chk++;
    if ({rs232_tx, tx_buffer_full, tx_half_full, tx_busy} !== 4'b1000)
      $display("FAIL reset_async: tx/full/half/busy=%b want 1000",
               {rs232_tx, tx_buffer_full, tx_half_full, tx_busy});
    else n_pass++;
    repeat (3) @(posedge clk);
    #4;
    pb_reset = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 8'h00);
    n_chk++;
    if (m_mis !== 0)
      $display("FAIL reset_idle: %0d cycles differ, first edge %0d got %b want %b", m_mis, mis_edge, mis_act, mis_exp);
    else n_pass++;
    m_mis = 0;
  endtask

  task automatic test_single_byte();
    logic [9:0] cap = '0;
    logic first = 1'bx;
    int busy_n = 0;
    rx_q.delete();
    cyc(1'b1, 8'h03, 8'h55);
    for (int i = 1; i <= 45; i++) begin
      cyc(1'b0, 8'h00, 8'h00);
      if (i == 1) first = rs232_tx;
      if (i <= 40 && ((i - 1) % 4) == 1) cap[(i-1)/4] = rs232_tx;
      if (tx_busy === 1'b1) busy_n++;
    end
    n_chk++;
    if (first !== 1'b0) $display("FAIL single_fall: line one cycle after strobe=%b want 0", first);
    else n_pass++;
    n_chk++;
    if (cap !== 10'b1010101010) $display("FAIL single_pattern: bits(stop..start)=%b want 1010101010", cap);
    else n_pass++;
    n_chk++;
    if (busy_n !== 40) $display("FAIL single_busy: busy cycles after fall=%0d want 40", busy_n);
    else n_pass++;
    n_chk++;
    if (rx_q.size() !== 1 || rx_q[0] !== 8'h55) $display("FAIL single_rx: got %0d bytes first=%h want 1 byte 55", rx_q.size(), rx_q.size() ? rx_q[0] : 8'hxx);
    else n_pass++;
    n_chk++;
    if (m_mis !== 0) $display("FAIL single_model: %0d cycles differ, first edge %0d got %b want %b", m_mis, mis_edge, mis_act, mis_exp);
    else n_pass++;
    m_mis = 0;
  endtask

  task automatic test_port_decode();
    int bad = 0;
    cyc(1'b1, 8'h01, 8'hAA);
    if (rs232_tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    cyc(1'b1, 8'h02, 8'hAA);
    for (int i = 0; i < 6; i++) begin
      if (rs232_tx !== 1'b1 || tx_busy !== 1'b0 || tx_half_full !== 1'b0) bad++;
      cyc(1'b0, 8'h00, 8'h00);
    end
    n_chk++;
    if (bad !== 0) $display("FAIL port_decode: %0d cycles with activity, want 0", bad);
    else n_pass++;
    n_chk++;
    if (m_mis !== 0) $display("FAIL port_model: %0d cycles differ, first edge %0d got %b want %b", m_mis, mis_edge, mis_act, mis_exp);
    else n_pass++;
    m_mis = 0;
  endtask

  task automatic test_overflow();
    logic [7:0] exp_q[$];
    logic ok;
    // Idle FSM: the first byte pops at once, so all 17 fit.
    rx_q.delete();
    for (int i = 0; i <= 16; i++) cyc(1'b1, 8'h03, 8'(i));
    n_chk++;
    if (tx_buffer_full !== 1'b1) $display("FAIL ovf_idle_full: full=%b want 1", tx_buffer_full);
    else n_pass++;
    drain();
    exp_q.delete();
    for (int i = 0; i <= 16; i++) exp_q.push_back(8'(i));
    ok = (rx_q.size() == exp_q.size());
    for (int i = 0; i < rx_q.size() && ok; i++) if (rx_q[i] !== exp_q[i]) ok = 1'b0;
    n_chk++;
    if (!ok) $display("FAIL ovf_idle_rx: got %0d bytes want %0d (00..10)", rx_q.size(), exp_q.size());
    else n_pass++;
    // Busy FSM: only 16 fit, 0x10 is dropped.
    rx_q.delete();
    cyc(1'b1, 8'h03, 8'hEE);
    cyc(1'b0, 8'h00, 8'h00);
    for (int i = 0; i <= 16; i++) cyc(1'b1, 8'h03, 8'(i));
    n_chk++;
    if (tx_buffer_full !== 1'b1) $display("FAIL ovf_busy_full: full=%b want 1", tx_buffer_full);
    else n_pass++;
    drain();
    exp_q.delete();
    exp_q.push_back(8'hEE);
    for (int i = 0; i <= 15; i++) exp_q.push_back(8'(i));
    ok = (rx_q.size() == exp_q.size());
    for (int i = 0; i < rx_q.size() && ok; i++) if (rx_q[i] !== exp_q[i]) ok = 1'b0;
    n_chk++;
    if (!ok) $display("FAIL ovf_busy_rx: got %0d bytes want %0d (EE,00..0F)", rx_q.size(), exp_q.size());
    else n_pass++;
    n_chk++;
    if (m_mis !== 0) $display("FAIL ovf_model: %0d cycles differ, first edge %0d got %b want %b", m_mis, mis_edge, mis_act, mis_exp);
    else n_pass++;
    m_mis = 0;
  endtask

  task automatic test_back_to_back();
    logic seen = 1'b0;
    int busy_n = 0;
    rx_q.delete();
    for (int i = 0; i < 250; i++) begin
      if (i < 3) cyc(1'b1, 8'h03, 8'(8'h31 + i));
      else cyc(1'b0, 8'h00, 8'h00);
      if (!seen && rs232_tx === 1'b0) seen = 1'b1;
      if (seen && tx_busy === 1'b1) busy_n++;
      if (seen && tx_busy === 1'b0) break;
    end
    n_chk++;
    if (busy_n !== 3 * FRAME) $display("FAIL b2b_length: cycles from first start to idle=%0d want %0d", busy_n, 3 * FRAME);
    else n_pass++;
    n_chk++;
    if (rx_q.size() !== 3 || rx_q[0] !== 8'h31 || rx_q[1] !== 8'h32 || rx_q[2] !== 8'h33)
      $display("FAIL b2b_rx: got %0d bytes want 31 32 33", rx_q.size());
    else n_pass++;
    n_chk++;
    if (m_mis !== 0) $display("FAIL b2b_model: %0d cycles differ, first edge %0d got %b want %b", m_mis, mis_edge, mis_act, mis_exp);
    else n_pass++;
    m_mis = 0;
  endtask

  task automatic test_full_pop_collision();
    logic ok;
    rx_q.delete();
    cyc(1'b1, 8'h03, 8'hA0);
    for (int i = 1; i <= 16; i++) cyc(1'b1, 8'h03, 8'(8'hA0 + i));
    for (int i = 0; i < 100; i++) begin
      if (m_end - m_edge == 1) break;
      cyc(1'b0, 8'h00, 8'h00);
    end
    n_chk++;
    if (tx_buffer_full !== 1'b1) $display("FAIL coll_pre_full: full=%b want 1", tx_buffer_full);
    else n_pass++;
    cyc(1'b1, 8'h03, 8'h99);
    n_chk++;
    if ({tx_buffer_full, tx_half_full} !== 2'b01) $display("FAIL coll_post: full,half=%b want 01", {tx_buffer_full, tx_half_full});
    else n_pass++;
    drain();
    ok = (rx_q.size() == 17);
    for (int i = 0; i < rx_q.size() && ok; i++) if (rx_q[i] !== 8'(8'hA0 + i)) ok = 1'b0;
    n_chk++;
    if (!ok) $display("FAIL coll_rx: got %0d bytes want 17 (A0..B0, no 99)", rx_q.size());
    else n_pass++;
    n_chk++;
    if (m_mis !== 0) $display("FAIL coll_model: %0d cycles differ, first edge %0d got %b want %b", m_mis, mis_edge, mis_act, mis_exp);
    else n_pass++;
    m_mis = 0;
  endtask

  task automatic test_random();
    logic ok;
    logic stb;
    logic [7:0] pid;
    rx_q.delete();
    m_sent.delete();
    for (int i = 0; i < 500; i++) begin
      stb = ($urandom_range(0, 99) < ((i < 250) ? 60 : 4));
      pid = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h03;
      cyc(stb, pid, 8'($urandom));
    end
    drain();
    ok = (rx_q.size() == m_sent.size());
    for (int i = 0; i < rx_q.size() && ok; i++) if (rx_q[i] !== m_sent[i]) ok = 1'b0;
    n_chk++;
    if (!ok) $display("FAIL rand_rx: got %0d bytes want %0d in model order", rx_q.size(), m_sent.size());
    else n_pass++;
    n_chk++;
    if (m_mis !== 0) $display("FAIL rand_model: %0d cycles differ, first edge %0d got %b want %b", m_mis, mis_edge, mis_act, mis_exp);
    else n_pass++;
    m_mis = 0;
  endtask

  task automatic test_reset_mid_frame();
    logic found = 1'b0;
    cyc(1'b1, 8'h03, 8'hC3);
    cyc(1'b1, 8'h03, 8'h11);
    cyc(1'b1, 8'h03, 8'h22);
    for (int i = 0; i < 100; i++) begin
      if (m_edge < m_end && (m_edge - m_start) == 17) begin
        found = 1'b1;
        break;
      end
      cyc(1'b0, 8'h00, 8'h00);
    end
    n_chk++;
    if (!found) $display("FAIL rst_reach_bit3: data bit 3 not reached, got no frame want frame");
    else n_pass++;
    n_chk++;
    if (m_mis !== 0) $display("FAIL rst_pre_model: %0d cycles differ, first edge %0d got %b want %b", m_mis, mis_edge, mis_act, mis_exp);
    else n_pass++;
    m_mis = 0;
    #2;
    pb_reset = 1'b1;
    #1;
    n_chk++;
    if ({rs232_tx, tx_buffer_full, tx_half_full, tx_busy} !== 4'b1000)
      $display("FAIL rst_async: tx/full/half/busy=%b want 1000", {rs232_tx, tx_buffer_full, tx_half_full, tx_busy});
    else n_pass++;
    @(posedge clk);
    #1;
    n_chk++;
    if ({rs232_tx, tx_buffer_full, tx_half_full, tx_busy} !== 4'b1000)
      $display("FAIL rst_held: tx/full/half/busy=%b want 1000", {rs232_tx, tx_buffer_full, tx_half_full, tx_busy});
    else n_pass++;
    #3;
    pb_reset = 1'b0;
    mq.delete();
    m_sent.delete();
    m_end = 0;
    for (int i = 0; i < 50; i++) cyc(1'b0, 8'h00, 8'h00);
    rx_q.delete();
    cyc(1'b1, 8'h03, 8'h7E);
    drain();
    n_chk++;
    if (rx_q.size() !== 1 || rx_q[0] !== 8'h7E)
      $display("FAIL rst_after_rx: got %0d bytes first=%h want 1 byte 7E", rx_q.size(), rx_q.size() ? rx_q[0] : 8'hxx);
    else n_pass++;
    n_chk++;
    if (m_mis !== 0) $display("FAIL rst_post_model: %0d cycles differ, first edge %0d got %b want %b", m_mis, mis_edge, mis_act, mis_exp);
    else n_pass++;
    m_mis = 0;
  endtask

  initial begin
    pb_reset        = 1'b1;
    pb_write_strobe = 1'b0;
    pb_port_id      = 8'h00;
    pb_out_port     = 8'h00;
    test_reset();
    test_single_byte();
    test_port_decode();
    test_overflow();
    test_back_to_back();
    test_full_pop_collision();
    test_random();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

PicoBlaze-facing UART transmitter with a transmit FIFO. It accepts bytes written by the CPU to its output port and serializes them as 8N1 frames on `rs232_tx`. It also returns buffer status that the top level routes to the CPU's input-port mux. It is the transmit-direction counterpart to the receive/loopback handling in the PicoBlaze systems.

## Interface
Parameters:
- `CLK_HZ`, default 100_000_000: clock frequency in Hz.
- `BAUD`, default 115200: line rate. Bit period `DIV = CLK_HZ/BAUD`, integer truncation (868 at defaults). `DIV` must be ≥ 2.
- `DEPTH`, default 16: FIFO entries. Must be a power of 2, ≥ 4.
- `PORT`, default 8'h03: PicoBlaze output port number for TX data.

Ports:
- `clk`, in, 1: system clock.
- `pb_reset`, in, 1: reset, asynchronous, active-high.
- `pb_port_id`, in, 8: PicoBlaze port_id.
- `pb_out_port`, in, 8: PicoBlaze out_port data.
- `pb_write_strobe`, in, 1: PicoBlaze write_strobe.
- `tx_buffer_full`, out, 1: registered; high when FIFO count == `DEPTH`.
- `tx_half_full`, out, 1: registered; high when count ≥ `DEPTH/2`.
- `tx_busy`, out, 1: registered; high when the FSM is not IDLE or count ≠ 0.
- `rs232_tx`, out, 1: serial line. Idles high.

## Operation
- Write accept: `pb_write_strobe & (pb_port_id == PORT) & (count < DEPTH)`, using the count before the edge.
  - On accept, store `pb_out_port` at the write pointer and advance the pointer.
  - A write while full is silently dropped. Count and pointers are unchanged.
  - There is no bypass: if full and a pop occurs in the same cycle, the write is still dropped.
- Pointers are log2(`DEPTH`) bits and wrap modulo `DEPTH`. Count is log2(`DEPTH`)+1 bits.
- Simultaneous accept and pop leave count unchanged; both pointers advance.
- FSM states: IDLE, START, DATA, STOP. A baud counter runs 0..`DIV`-1 in every non-IDLE state.
  - IDLE: `rs232_tx`=1. If count ≠ 0, pop the head into the shift register, clear the baud counter, and go to START.
  - START: `rs232_tx`=0 for `DIV` cycles, then go to DATA with bit index 0.
  - DATA: `rs232_tx` = `shift[0]` (LSB first). At each bit end, shift right and increment the index. After bit 7 ends, go to STOP.
  - STOP: `rs232_tx`=1 for `DIV` cycles. At the end, if count ≠ 0, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- `rs232_tx` is driven from a register (glitch-free).
- Reset values: `rs232_tx`=1, `tx_buffer_full`=0, `tx_half_full`=0, `tx_busy`=0, count=0, pointers=0, state=IDLE.
- Reset mid-frame aborts the frame: the line goes high asynchronously and FIFO contents are discarded.

## Timing
- Write strobe sampled at edge k, FIFO empty, FSM IDLE:
  - Count becomes 1 at edge k.
  - Pop, and `rs232_tx` falls, at edge k+1.
- Frame length: exactly 10·`DIV` cycles from the falling start edge to the end of the stop bit.
- Back-to-back frames: the next start bit begins on the edge immediately after the previous stop bit's `DIV` cycles.
- Status flags reflect count after each edge, with 0-cycle lag relative to count:
  - `tx_buffer_full` rises on the edge that accepts the `DEPTH`th byte.
  - It falls on the edge of the next pop.
- `tx_busy` rises with the first accepted write. It falls on the edge where STOP ends with an empty FIFO.
- Sustained throughput is one byte per 10·`DIV` cycles. The CPU must poll `tx_buffer_full` to avoid drops.

## Test plan
- Single byte: write 0x55 to port 03 with `DIV`=4.
  - `rs232_tx` falls 1 cycle after the strobe edge.
  - Line pattern per 4-cycle bit: 0,1,0,1,0,1,0,1,0,1.
  - `tx_busy` drops after 40 cycles.
- Port decode: write 0xAA to port 01 and port 02.
  - Count stays 0 and `rs232_tx` stays 1.
  - `tx_busy` stays 0.
- Overflow: 17 consecutive writes of 0x00..0x10 on consecutive cycles, `DEPTH`=16.
  - The first write is popped at once and the FIFO holds 0x01..0x10.
  - `tx_buffer_full`=1; 0x10 fits.
  - Repeat with the FSM busy: 0x10 is dropped.
  - Received stream contains exactly the accepted bytes, in order.
- Back-to-back: queue 0x31, 0x32, 0x33.
  - Three frames decode correctly.
  - No idle cycles between stop and next start.
  - Total is 30·`DIV` cycles.
- Full plus pop collision: FIFO full, write strobe on the same edge STOP pops.
  - Write is dropped; count goes `DEPTH`→`DEPTH`-1.
  - `tx_buffer_full` falls.
- Reset mid-frame: assert `pb_reset` during DATA bit 3.
  - `rs232_tx`=1 immediately; all flags 0.
  - After release, a new write of 0x7E transmits cleanly.
